program_buffer: RTL and testbench

//  Nibble program store sitting directly upstream of stack_cpu: feeds its 4-bit inbits.

---
 rtl/program_buffer_pkg.sv | 20 ++
 rtl/program_buffer_nibble_ram.sv | 38 +++
 rtl/program_buffer.sv | 137 +++++++++++++
 tb/tb_program_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_buffer_pkg.sv
// Purpose : shared types and constants for the nibble program buffer.
// Latency : n/a (types only).
// Backpressure: n/a.
package program_buffer_pkg;

   // Width of one program element as consumed by stack_cpu inbits.
   localparam int NIB_W = 4;

   // Replay controller states; encodings are fixed so other blocks can
   // decode them directly.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // loading; no replay
      ST_RUN  = 2'b01,   // replaying, nibble/valid driven
      ST_DONE = 2'b10    // last nibble consumed, waiting for run to drop
   } pb_state_t;

   // Zero nibble driven whenever no replay is active.
   localparam logic [NIB_W-1:0] NIB_IDLE = '0;

endpackage

// File: rtl/program_buffer_nibble_ram.sv
// Purpose : DEPTH x 4-bit register file holding the stored program.
// Latency : write lands on the next posedge; read is combinational.
// Backpressure: none; the owner decides when a write is legal.
//
// Ports:
//   clk    in   system clock
//   we     in   write strobe for waddr/wdata
//   waddr  in   write slot
//   wdata  in   nibble to store
//   raddr  in   read slot
//   rdata  out  nibble at raddr (asynchronous)
module program_buffer_nibble_ram
   import program_buffer_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [NIB_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [NIB_W-1:0]  rdata
);

   // Contents are deliberately not reset: the program only becomes
   // observable through slots below count, which are always written first.
   logic [NIB_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/program_buffer.sv
// Purpose : loads a nibble program from the host, then replays it to stack_cpu.
// Latency : first nibble valid 1 cycle after run sampled in IDLE; each adv shows the next nibble 1 cycle later.
// Backpressure: consumer paces replay with adv; writes while full are dropped and flagged in overflow.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (highest priority)
//   clear           synchronous program wipe (count, pointers, flags, state)
//   wr_en, wr_data  append one nibble per cycle while idle
//   run             level: start/continue replay; dropping it aborts or leaves DONE
//   adv             consumer strobe: current nibble consumed
//   nibble, valid   current program nibble, qualified while replaying
//   done            replay finished
//   full, overflow  store full; sticky write-while-full flag
//   count           nibbles stored (ADDR_W+1 bits so DEPTH is representable)
module program_buffer
   import program_buffer_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter bit LOOP   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [NIB_W-1:0]  wr_data,
   input  logic              run,
   input  logic              adv,
   output logic [NIB_W-1:0]  nibble,
   output logic              valid,
   output logic              done,
   output logic              full,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   pb_state_t         state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt_q;
   logic              ovf_q;
   logic [NIB_W-1:0]  rd_nib;
   logic              ram_we;
   logic              at_last;
   logic              wipe;

   // rst and clear share the same effect on control state.
   assign wipe = rst | clear;

   assign full = (cnt_q == DEPTH_C);

   // rd_ptr points at the final stored nibble. Only evaluated in RUN,
   // where count is at least 1, so the subtraction never underflows.
   assign at_last = ({1'b0, rd_ptr} == (cnt_q - 1'b1));

   // Writes only land while idle and not full; a concurrent wipe wins.
   assign ram_we = (state == ST_IDLE) && wr_en && !full && !wipe;

   program_buffer_nibble_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_nib)
   );

   always_ff @(posedge clk) begin
      if (wipe) begin
         state  <= ST_IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               // A write takes the whole cycle; run is only honoured on a
               // cycle without wr_en.
               if (wr_en) begin
                  if (!full) begin
                     // wr_ptr wraps to 0 on the DEPTH-th write; full then
                     // blocks any further advance.
                     wr_ptr <= wr_ptr + 1'b1;
                     cnt_q  <= cnt_q + 1'b1;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end else if (run && (cnt_q != '0)) begin
                  state  <= ST_RUN;
                  rd_ptr <= '0;
               end
            end

            ST_RUN: begin
               if (!run) begin
                  // Abort: adv in the same cycle is ignored.
                  state  <= ST_IDLE;
                  rd_ptr <= '0;
               end else if (adv) begin
                  if (!at_last) begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end else if (LOOP) begin
                     rd_ptr <= '0;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               if (!run) begin
                  state  <= ST_IDLE;
                  rd_ptr <= '0;
               end
            end

            default: begin
               state  <= ST_IDLE;
               rd_ptr <= '0;
            end
         endcase
      end
   end

   assign valid    = (state == ST_RUN);
   assign done     = (state == ST_DONE);
   assign nibble   = valid ? rd_nib : NIB_IDLE;
   assign overflow = ovf_q;
   assign count    = cnt_q;

endmodule

// File: tb/tb_program_buffer.sv
// Purpose : self-checking bench for program_buffer (LOOP=0 and LOOP=1 instances side by side).
// Latency : n/a.
// Backpressure: n/a.
module tb_program_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_data = 4'h0;
   logic       run = 1'b0;
   logic       adv = 1'b0;

   logic [3:0] nibble0, nibble1;
   logic       valid0, valid1, done0, done1, full0, full1, ovf0, ovf1;
   logic [4:0] count0, count1;

   int tests = 0;
   int fails = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   program_buffer #(.DEPTH(16), .ADDR_W(4), .LOOP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
      .run(run), .adv(adv), .nibble(nibble0), .valid(valid0), .done(done0),
      .full(full0), .overflow(ovf0), .count(count0)
   );

   program_buffer #(.DEPTH(16), .ADDR_W(4), .LOOP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
      .run(run), .adv(adv), .nibble(nibble1), .valid(valid1), .done(done1),
      .full(full1), .overflow(ovf1), .count(count1)
   );

   // ---------------- behavioural model ----------------
   // Program is an array filled in append order; mode 0=loading,
   // 1=replaying, 2=finished. Index 0 models LOOP=0, index 1 LOOP=1.
   int m_mem  [2][16];
   int m_cnt  [2];
   int m_pos  [2];
   int m_mode [2];
   bit m_ovf  [2];

   task automatic model_step(input int k);
      if (rst || clear) begin
         m_mode[k] = 0; m_cnt[k] = 0; m_pos[k] = 0; m_ovf[k] = 1'b0;
      end else if (m_mode[k] == 0) begin
         if (wr_en) begin
            if (m_cnt[k] < 16) begin
               m_mem[k][m_cnt[k]] = int'(wr_data);
               m_cnt[k] = m_cnt[k] + 1;
            end else begin
               m_ovf[k] = 1'b1;
            end
         end else if (run && m_cnt[k] > 0) begin
            m_mode[k] = 1; m_pos[k] = 0;
         end
      end else if (m_mode[k] == 1) begin
         if (!run) begin
            m_mode[k] = 0;
         end else if (adv) begin
            if (m_pos[k] + 1 < m_cnt[k]) m_pos[k] = m_pos[k] + 1;
            else if (k == 1)             m_pos[k] = 0;
            else                         m_mode[k] = 2;
         end
      end else begin
         if (!run) m_mode[k] = 0;
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_pos[k] = 0; m_mode[k] = 0; m_ovf[k] = 1'b0;
         for (int s = 0; s < 16; s++) m_mem[k][s] = 0;
      end
   end

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_nib(input int k);
      return (m_mode[k] == 1) ? 8'(m_mem[k][m_pos[k]]) : 8'h0;
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("m0.nibble",   8'(nibble0), exp_nib(0));
         chk("m0.valid",    8'(valid0),  8'(m_mode[0] == 1));
         chk("m0.done",     8'(done0),   8'(m_mode[0] == 2));
         chk("m0.full",     8'(full0),   8'(m_cnt[0] == 16));
         chk("m0.overflow", 8'(ovf0),    8'(m_ovf[0]));
         chk("m0.count",    8'(count0),  8'(m_cnt[0]));
         chk("m1.nibble",   8'(nibble1), exp_nib(1));
         chk("m1.valid",    8'(valid1),  8'(m_mode[1] == 1));
         chk("m1.done",     8'(done1),   8'(m_mode[1] == 2));
         chk("m1.full",     8'(full1),   8'(m_cnt[1] == 16));
         chk("m1.overflow", 8'(ovf1),    8'(m_ovf[1]));
         chk("m1.count",    8'(count1),  8'(m_cnt[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [3:0] prog1 [5];
      logic [3:0] seq1  [4];
      prog1[0] = 4'h1; prog1[1] = 4'h5; prog1[2] = 4'h1; prog1[3] = 4'h3; prog1[4] = 4'hA;

      // Reset state
      rst = 1'b1;
      tick();
      cmp_on = 1'b1;
      chk("rst.valid", 8'(valid0), 8'h0);
      chk("rst.done",  8'(done0),  8'h0);
      chk("rst.full",  8'(full0),  8'h0);
      chk("rst.count", 8'(count0), 8'h0);
      chk("rst.nibble",8'(nibble0),8'h0);
      rst = 1'b0;

      // 1: load 1,5,1,3,A and replay with adv every cycle
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = prog1[i];
         tick();
      end
      wr_en = 1'b0;
      chk("t1.count", 8'(count0), 8'd5);
      run = 1'b1; adv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1.nibble", 8'(nibble0), 8'(prog1[i]));
         chk("t1.valid",  8'(valid0),  8'h1);
      end
      tick();
      chk("t1.done",     8'(done0),   8'h1);
      chk("t1.valid_end",8'(valid0),  8'h0);
      chk("t1.nib_end",  8'(nibble0), 8'h0);
      chk("t1.loop_wrap",8'(nibble1), 8'h1);

      // 6: drop run, raise again -> replay from slot 0
      run = 1'b0; adv = 1'b0;
      tick();
      chk("t6.idle_done", 8'(done0), 8'h0);
      run = 1'b1;
      tick();
      chk("t6.replay0", 8'(nibble0), 8'h1);
      adv = 1'b1;
      tick();
      chk("t6.replay1", 8'(nibble0), 8'h5);
      run = 1'b0; adv = 1'b0;
      tick();
      chk("t6.abort", 8'(valid0), 8'h0);

      // 3: run with empty store; wr_en and run together
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t3.clear_cnt", 8'(count0), 8'h0);
      run = 1'b1;
      tick();
      chk("t3.empty_run", 8'(valid0), 8'h0);
      wr_en = 1'b1; wr_data = 4'h7;
      tick();
      chk("t3.wr_run_cnt", 8'(count0), 8'd1);
      chk("t3.wr_run_vld", 8'(valid0), 8'h0);
      wr_data = 4'h8;
      tick();
      chk("t3.cnt2", 8'(count0), 8'd2);
      wr_en = 1'b0;
      tick();
      chk("t3.run_vld", 8'(valid0),  8'h1);
      chk("t3.run_nib", 8'(nibble0), 8'h7);

      // 4: LOOP=1 with program 7,8
      seq1[0] = 4'h8; seq1[1] = 4'h7; seq1[2] = 4'h8; seq1[3] = 4'h7;
      adv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4.loop_nib",  8'(nibble1), 8'(seq1[i]));
         chk("t4.loop_done", 8'(done1),   8'h0);
      end
      chk("t4.noloop_done", 8'(done0), 8'h1);
      run = 1'b0; adv = 1'b0;
      tick();

      // 2: fill to DEPTH then one more write
      clear = 1'b1;
      tick();
      clear = 1'b0;
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 4'(i + 1);
         tick();
         if (i == 14) chk("t2.not_full", 8'(full0), 8'h0);
      end
      chk("t2.full",    8'(full0),  8'h1);
      chk("t2.ovf_pre", 8'(ovf0),   8'h0);
      chk("t2.cnt16",   8'(count0), 8'd16);
      wr_data = 4'hE;
      tick();
      chk("t2.ovf",     8'(ovf0),   8'h1);
      chk("t2.cnt_hold",8'(count0), 8'd16);
      wr_en = 1'b0; run = 1'b1;
      tick();
      chk("t2.slot0", 8'(nibble0), 8'h1);

      // 5: reset mid-run at rd_ptr=2
      adv = 1'b1;
      tick();
      tick();
      chk("t5.slot2", 8'(nibble0), 8'h3);
      rst = 1'b1;
      tick();
      rst = 1'b0; adv = 1'b0;
      chk("t5.valid", 8'(valid0), 8'h0);
      chk("t5.count", 8'(count0), 8'h0);
      chk("t5.ovf",   8'(ovf0),   8'h0);
      tick();
      chk("t5.run_empty", 8'(valid0), 8'h0);
      run = 1'b0;
      tick();

      // Random phase, checked cycle by cycle against the model
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         clear   = ($urandom_range(0, 99) < 2);
         wr_en   = ($urandom_range(0, 99) < 35);
         wr_data = 4'($urandom_range(0, 15));
         adv     = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 99) < 10) run = ~run;
         tick();
      end
      rst = 1'b0; clear = 1'b0; wr_en = 1'b0; run = 1'b0; adv = 1'b0;
      tick();
      @(negedge clk);
      cmp_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
